vld_rdy_result_fifo: RTL

//  Small result buffer sitting directly downstream of the latency-pipelined
//  vld/rdy flow-control stage. Absorbs completed results (in_vld/in_data) and

---
 rtl/vld_rdy_result_fifo_pkg.sv | 12 +
 rtl/vld_rdy_result_fifo_wrap_ptr_cnt.sv | 28 ++
 rtl/vld_rdy_result_fifo.sv | 100 ++++++++++
 3 files changed

// File: rtl/vld_rdy_result_fifo_pkg.sv
// Shared constants for the result FIFO and its pointer helper.
package vld_rdy_result_fifo_pkg;

    // Level of rst that holds the block in reset (active-low).
    localparam logic RESET_STATE = 1'b0;

    // True while the asynchronous reset is applied.
    function automatic logic in_reset(input logic rst_level);
        return rst_level == RESET_STATE;
    endfunction

endpackage

// File: rtl/vld_rdy_result_fifo_wrap_ptr_cnt.sv
// Wrapping entry pointer for the result FIFO: counts 0..DEPTH-1, then returns to 0.
module wrap_ptr_cnt
    import vld_rdy_result_fifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Pointer register: sync clear wins over increment; increment wraps after the last entry.
    always_ff @(posedge clk or negedge rst) begin
        if (in_reset(rst)) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/vld_rdy_result_fifo.sv
// Result buffer behind the vld/rdy pipeline: flop-array FIFO, flags decoded from the
// registered occupancy only, so there is no combinational path between the two sides.
module vld_rdy_result_fifo
    import vld_rdy_result_fifo_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              reset_state,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_rdy,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_rdy,
    output logic [CNT_W-1:0]  occupancy,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    // Handshakes and status flags, all derived from the registered count.
    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        empty     = (count == '0);
        in_rdy    = ~full;
        out_vld   = ~empty;
        occupancy = count;
        push      = in_vld & in_rdy;
        pop       = out_vld & out_rdy;
        out_data  = mem[rd_ptr];
    end

    wrap_ptr_cnt #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (reset_state),
        .inc (push),
        .ptr (wr_ptr)
    );

    wrap_ptr_cnt #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (reset_state),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Occupancy: up on push only, down on pop only, cleared by reset_state regardless of traffic.
    always_ff @(posedge clk or negedge rst) begin
        if (in_reset(rst)) begin
            count <= '0;
        end else if (reset_state) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage: write at wr_ptr on an accepted push; a word offered during reset_state is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (in_reset(rst)) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !reset_state) begin
            mem[wr_ptr] <= in_data;
        end
    end

`ifndef SYNTHESIS
    a_depth_min: assert property (@(posedge clk) DEPTH >= 2)
        else $error("vld_rdy_result_fifo: DEPTH must be at least 2");

    a_in_data_stable: assert property (@(posedge clk) disable iff (in_reset(rst))
        (in_vld && !in_rdy) |=> $stable(in_data))
        else $error("vld_rdy_result_fifo: in_data changed while stalled");

    a_count_bound: assert property (@(posedge clk) disable iff (in_reset(rst))
        count <= CNT_W'(DEPTH))
        else $error("vld_rdy_result_fifo: occupancy above DEPTH");
`endif

endmodule
